// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions.
// Holds the register file geometry, the architectural register indices with
// fixed meaning, and the ALU function encodings so decode and ALU agree.
package mips_pkg;

    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 5;
    localparam int REG_COUNT = 32;

    localparam logic [ADDR_W-1:0] ZERO_REG = 5'd0;
    localparam logic [ADDR_W-1:0] RA_REG   = 5'd31;

    typedef enum logic [2:0] {
        ADD = 3'd0,
        SUB = 3'd1,
        AND = 3'd2,
        OR  = 3'd3,
        NOR = 3'd4,
        SLT = 3'd5
    } alu_func_e;

endpackage

// File: rtl/mips_regfile.sv
// 32 x 32 general-purpose register file for the single-cycle MIPS datapath.
// Two combinational read ports, one write port committed on the rising edge,
// register 0 hardwired to zero, synchronous active-high reset.
// Optional build macro MIPS_REGFILE_WRITE_BYPASS_EN adds a write-through
// bypass so a read of the register being written sees write_data in the same
// cycle (for the pipelined CPU); without it a read-during-write returns the
// old contents.
module mips_regfile
#(
    parameter int DATA_W    = mips_pkg::DATA_W,
    parameter int REG_COUNT = mips_pkg::REG_COUNT,
    parameter int ADDR_W    = mips_pkg::ADDR_W
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    input  logic              reg_write,
    input  logic [ADDR_W-1:0] write_addr,
    input  logic [DATA_W-1:0] write_data
);

    localparam logic [ADDR_W-1:0] ZERO_ADDR = mips_pkg::ZERO_REG;

    // Entry 0 is only ever cleared, so synthesis reduces it to constant zero.
    logic [DATA_W-1:0] r_regs [REG_COUNT];

    logic              w_write_en;
    logic [DATA_W-1:0] w_rs_stored;
    logic [DATA_W-1:0] w_rt_stored;

    assign w_write_en = reg_write && (write_addr != ZERO_ADDR);

    // Reset clears every entry and wins over a same-edge write.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_write_en) begin
            r_regs[write_addr] <= write_data;
        end
    end

    // Stored-value read muxes; address 0 is forced to zero.
    always_comb begin
        w_rs_stored = (rs_addr == ZERO_ADDR) ? '0 : r_regs[rs_addr];
        w_rt_stored = (rt_addr == ZERO_ADDR) ? '0 : r_regs[rt_addr];
    end

`ifdef MIPS_REGFILE_WRITE_BYPASS_EN
    logic w_bypass_ok;
    logic w_rs_hit;
    logic w_rt_hit;

    assign w_bypass_ok = w_write_en && !reset;
    assign w_rs_hit    = w_bypass_ok && (rs_addr == write_addr);
    assign w_rt_hit    = w_bypass_ok && (rt_addr == write_addr);

    // Each port independently forwards the in-flight write value.
    always_comb begin
        rs_data = w_rs_hit ? write_data : w_rs_stored;
        rt_data = w_rt_hit ? write_data : w_rt_stored;
    end
`else
    // No bypass: a read during a write returns the pre-edge contents.
    always_comb begin
        rs_data = w_rs_stored;
        rt_data = w_rt_stored;
    end
`endif

endmodule
